sao_stat_accum: RTL

SAO_STAT_ACCUM -- requirements
Module: sao_stat_accum

---
 rtl/sao_stat_accum_pkg.sv | 37 +++
 rtl/sao_stat_accum_if.sv | 39 +++
 rtl/sao_stat_blk_reduce.sv | 36 +++
 rtl/sao_stat_accum.sv | 105 ++++++++++
 4 files changed

// File: rtl/sao_stat_accum_pkg.sv
// Shared SAO statistics definitions: sign/category types, widths and the
// edge-offset classifier used by the statistics blocks.
package sao_stat_accum_pkg;

   localparam int DIFF_W = 5;
   localparam int PSUM_W = 9;   // 16 pixels * |diff|<=16
   localparam int PCNT_W = 5;   // 0..16 pixels

   typedef logic signed [1:0] sao_sign_t;

   typedef enum logic [2:0] {
      CAT_NONE = 3'd0,
      CAT_1    = 3'd1,
      CAT_2    = 3'd2,
      CAT_3    = 3'd3,
      CAT_4    = 3'd4
   } sao_cat_e;

   typedef enum logic [1:0] {
      ACCUM  = 2'd0,
      DRAIN  = 2'd1,
      OUTPUT = 2'd2
   } sao_state_e;

   function automatic sao_cat_e sao_classify(sao_sign_t sl, sao_sign_t sr);
      logic signed [2:0] e;
      e = {sl[1], sl} + {sr[1], sr};
      case (e)
         -3'sd2:  return CAT_1;
         -3'sd1:  return CAT_2;
          3'sd1:  return CAT_3;
          3'sd2:  return CAT_4;
         default: return CAT_NONE;
      endcase
   endfunction

endpackage

// File: rtl/sao_stat_accum_if.sv
// Beat input and CTB result buses of the SAO statistics accumulator.
// SAO_STAT_MASK_EN adds the per-pixel availability mask.
interface sao_stat_accum_if
   import sao_stat_accum_pkg::*;
#(
   parameter int NUM_CAT = 4,
   parameter int SUM_W   = 18,
   parameter int CNT_W   = 13
);
   logic                                 in_valid;
   logic                                 in_ready;
   logic                                 in_last;
   sao_sign_t [0:3][0:3]                 sign_l;
   sao_sign_t [0:3][0:3]                 sign_r;
   logic      [0:3][0:3][DIFF_W-1:0]     diff;
`ifdef SAO_STAT_MASK_EN
   logic      [0:3][0:3]                 in_mask;
`endif
   logic                                 stat_valid;
   logic                                 stat_ready;
   logic      [1:NUM_CAT][SUM_W-1:0]     stat_sum;
   logic      [1:NUM_CAT][CNT_W-1:0]     stat_cnt;

   modport master (
`ifdef SAO_STAT_MASK_EN
      output in_mask,
`endif
      output in_valid, in_last, sign_l, sign_r, diff, stat_ready,
      input  in_ready, stat_valid, stat_sum, stat_cnt
   );

   modport slave (
`ifdef SAO_STAT_MASK_EN
      input  in_mask,
`endif
      input  in_valid, in_last, sign_l, sign_r, diff, stat_ready,
      output in_ready, stat_valid, stat_sum, stat_cnt
   );
endinterface

// File: rtl/sao_stat_blk_reduce.sv
// Classifies the 16 pixels of one 4x4 beat and reduces them into per-category
// partial diff sums and pixel counts (purely combinational).
module sao_stat_blk_reduce
   import sao_stat_accum_pkg::*;
#(
   parameter int NUM_CAT = 4
) (
   input  sao_sign_t [0:3][0:3]             sign_l,
   input  sao_sign_t [0:3][0:3]             sign_r,
   input  logic      [0:3][0:3][DIFF_W-1:0] diff,
   input  logic      [0:3][0:3]             mask,
   output logic      [1:NUM_CAT][PSUM_W-1:0] psum,
   output logic      [1:NUM_CAT][PCNT_W-1:0] pcnt
);

   sao_cat_e cat_px [16];

   for (genvar p = 0; p < 16; p++) begin : g_px
      assign cat_px[p] = mask[p/4][p%4] ? sao_classify(sign_l[p/4][p%4], sign_r[p/4][p%4])
                                        : CAT_NONE;
   end

   always_comb begin
      psum = '0;
      pcnt = '0;
      for (int k = 1; k <= NUM_CAT; k++) begin
         for (int p = 0; p < 16; p++) begin
            if (int'(cat_px[p]) == k) begin
               psum[k] = psum[k] + {{(PSUM_W-DIFF_W){diff[p/4][p%4][DIFF_W-1]}}, diff[p/4][p%4]};
               pcnt[k] = pcnt[k] + PCNT_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/sao_stat_accum.sv
// SAO edge-offset statistics accumulator: 2-stage reduce/accumulate of 4x4
// beats per CTB with a held result handshake. SAO_STAT_MASK_EN enables in_mask.
module sao_stat_accum
   import sao_stat_accum_pkg::*;
#(
   parameter int NUM_CAT = 4,
   parameter int SUM_W   = 18,
   parameter int CNT_W   = 13
) (
   input  logic             clk,
   input  logic             rst,
   sao_stat_accum_if.slave  bus
);

   sao_state_e state_q, state_d;
   logic       in_ready_c, stat_valid_c;
   logic       accept;

   logic [0:3][0:3]              mask;
   logic [1:NUM_CAT][PSUM_W-1:0] psum, s1_sum;
   logic [1:NUM_CAT][PCNT_W-1:0] pcnt, s1_cnt;
   logic                         s1_vld, s1_last;
   logic [1:NUM_CAT][SUM_W-1:0]  acc_sum;
   logic [1:NUM_CAT][CNT_W-1:0]  acc_cnt;

`ifdef SAO_STAT_MASK_EN
   assign mask = bus.in_mask;
`else
   assign mask = '1;
`endif

   sao_stat_blk_reduce #(.NUM_CAT(NUM_CAT)) u_reduce (
      .sign_l (bus.sign_l),
      .sign_r (bus.sign_r),
      .diff   (bus.diff),
      .mask   (mask),
      .psum   (psum),
      .pcnt   (pcnt)
   );

   assign accept = bus.in_valid && in_ready_c;

   always_comb begin
      state_d      = state_q;
      in_ready_c   = 1'b0;
      stat_valid_c = 1'b0;
      case (state_q)
         ACCUM: begin
            in_ready_c = 1'b1;
            if (bus.in_valid && bus.in_last) state_d = DRAIN;
         end
         DRAIN: begin
            if (s1_vld && s1_last) state_d = OUTPUT;
         end
         OUTPUT: begin
            stat_valid_c = 1'b1;
            if (bus.stat_ready) state_d = ACCUM;
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ACCUM;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld  <= 1'b0;
         s1_last <= 1'b0;
         s1_sum  <= '0;
         s1_cnt  <= '0;
      end else begin
         s1_vld <= accept;
         if (accept) begin
            s1_sum  <= psum;
            s1_cnt  <= pcnt;
            s1_last <= bus.in_last;
         end
      end
   end

   // Clearing on the output handshake lets the next CTB's first beat land on zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_sum <= '0;
         acc_cnt <= '0;
      end else if (state_q == OUTPUT && bus.stat_ready) begin
         acc_sum <= '0;
         acc_cnt <= '0;
      end else if (s1_vld) begin
         for (int k = 1; k <= NUM_CAT; k++) begin
            acc_sum[k] <= acc_sum[k] + {{(SUM_W-PSUM_W){s1_sum[k][PSUM_W-1]}}, s1_sum[k]};
            acc_cnt[k] <= acc_cnt[k] + {{(CNT_W-PCNT_W){1'b0}}, s1_cnt[k]};
         end
      end
   end

   assign bus.in_ready   = in_ready_c;
   assign bus.stat_valid = stat_valid_c;
   assign bus.stat_sum   = acc_sum;
   assign bus.stat_cnt   = acc_cnt;

endmodule
